// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side stage behind the control unit.
// Holds MAR/MDR. A rising edge on the level strobes Read/Write starts one
// req/ack transaction on a word-addressed RAM port. Read data is returned
// into MDR, and completion or timeout is reported back to the datapath.
//
// Ports:
//   Clock, Reset          rising-edge clock, async active-high reset
//   BusMuxOut             datapath bus; source for MAR, MDR and write data
//   MARin, MDRin          register load enables
//   Read, Write           level strobes; a transaction starts on the rising edge
//   MDataOut              MDR contents
//   MemBusy               high while a transaction is in progress
//   MemDone               one-cycle completion pulse
//   MemErr                one-cycle error pulse (timeout, collision, strobe while busy)
//   mem_req/we/addr/wdata request side of the RAM port
//   mem_rdata, mem_ack    response side of the RAM port
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  output logic [DATA_WIDTH-1:0] MDataOut,
  output logic                  MemBusy,
  output logic                  MemDone,
  output logic                  MemErr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned CountWidth = $clog2(TIMEOUT);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  req_q, req_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  read_q, write_q;
  logic                  err_q, err_d;
  logic                  err_pend_q, err_pend_d;
  logic                  rd_go, wr_go, err_event;

  assign rd_go = Read & ~read_q;
  assign wr_go = Write & ~write_q;

  always_comb begin
    state_d   = state_q;
    mar_d     = MARin ? BusMuxOut[ADDR_WIDTH-1:0] : mar_q;
    mdr_d     = mdr_q;
    addr_d    = addr_q;
    we_d      = we_q;
    req_d     = req_q;
    count_d   = count_q;
    err_event = 1'b0;

    // Lowest-precedence MDR source; overridden below by transaction captures.
    if (MDRin && !Read && state_q == StIdle) mdr_d = BusMuxOut;

    unique case (state_q)
      StIdle: begin
        if (rd_go && wr_go) begin
          err_event = 1'b1;
        end else if (rd_go || wr_go) begin
          addr_d  = mar_q;
          we_d    = wr_go;
          req_d   = 1'b1;
          count_d = '0;
          state_d = StReq;
          if (wr_go) mdr_d = BusMuxOut;
        end
      end
      StReq: begin
        err_event = rd_go | wr_go;
        if (mem_ack) begin
          if (!we_q) mdr_d = mem_rdata;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (count_q == CountLast) begin
          req_d     = 1'b0;
          err_event = 1'b1;
          state_d   = StIdle;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StDone: begin
        err_event = rd_go | wr_go;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An error raised on the cycle that enters DONE is deferred one cycle so
    // MemErr and MemDone never overlap.
    err_d      = (err_event | err_pend_q) & (state_d != StDone);
    err_pend_d = (err_event | err_pend_q) & (state_d == StDone);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      mar_q      <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      count_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      req_q      <= req_d;
      count_q    <= count_d;
      read_q     <= Read;
      write_q    <= Write;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign MDataOut  = mdr_q;
  assign MemBusy   = (state_q != StIdle);
  assign MemDone   = (state_q == StDone);
  assign MemErr    = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit. The bench plays the control unit and
// the RAM; a transaction-level model (RAM contents array, expected MDR, and
// expected cycle counts derived from the ack delay) predicts every outcome.
module tb_mem_access_unit;

  localparam int unsigned Aw      = 9;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Timeout = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [Dw-1:0] BusMuxOut = '0;
  logic          MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [Dw-1:0] MDataOut;
  logic          MemBusy, MemDone, MemErr;
  logic          mem_req, mem_we;
  logic [Aw-1:0] mem_addr;
  logic [Dw-1:0] mem_wdata;
  logic [Dw-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [Dw-1:0] ram_m [int];
  logic [Dw-1:0] mdr_m = '0;

  mem_access_unit #(
    .ADDR_WIDTH(Aw),
    .DATA_WIDTH(Dw),
    .TIMEOUT   (Timeout)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .BusMuxOut(BusMuxOut),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .Read     (Read),
    .Write    (Write),
    .MDataOut (MDataOut),
    .MemBusy  (MemBusy),
    .MemDone  (MemDone),
    .MemErr   (MemErr),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One complete transaction. delay = wait cycles before ack (>= Timeout means
  // no ack). poke > 0 re-raises the same strobe at that cycle of the access.
  task automatic do_txn(input bit is_wr, input logic [Aw-1:0] addr, input logic [Dw-1:0] data,
                        input int delay, input int poke);
    int req_n = 0, busy_n = 0, done_n = 0, err_n = 0, both_n = 0, waits = 0;
    int done_at = -1, first_req = -1;
    bit addr_bad = 0, we_bad = 0, wd_bad = 0, ended = 0, ok;
    logic [Dw-1:0] rval;
    ok = (delay < int'(Timeout));
    if (!is_wr) begin
      if (!ram_m.exists(int'(addr))) ram_m[int'(addr)] = $urandom;
      rval = ram_m[int'(addr)];
    end else begin
      rval = $urandom;
    end
    BusMuxOut = ($urandom & ~32'h1ff) | 32'(addr);
    MARin = 1'b1;
    tick();
    MARin = 1'b0;
    BusMuxOut = is_wr ? data : $urandom;
    if (is_wr) Write = 1'b1; else Read = 1'b1;
    tick();
    for (int c = 0; c < int'(Timeout) + 8; c++) begin
      mem_ack = 1'b0;
      if (MemBusy) busy_n++;
      if (MemDone) begin done_n++; done_at = c; end
      if (MemErr) err_n++;
      if (MemDone && MemErr) both_n++;
      if (mem_req) begin
        if (first_req < 0) first_req = c;
        req_n++;
        if (mem_addr !== addr) addr_bad = 1;
        if (mem_we !== is_wr) we_bad = 1;
        if (is_wr && mem_wdata !== data) wd_bad = 1;
        if (waits == delay) begin mem_ack = 1'b1; mem_rdata = rval; end
        else mem_rdata = $urandom;
        waits++;
      end
      if (c > 0 && !MemBusy) begin ended = 1; break; end
      // Noise on the datapath side while the access is in flight.
      Read      = !is_wr && (c == poke);
      Write     = is_wr && (c == poke);
      MARin     = 1'($urandom_range(0, 1));
      MDRin     = 1'($urandom_range(0, 1));
      BusMuxOut = $urandom;
      tick();
    end
    Read = 0; Write = 0; MARin = 0; MDRin = 0; mem_ack = 0;
    if (ok) begin
      mdr_m = is_wr ? data : rval;
      if (is_wr) ram_m[int'(addr)] = data;
    end else if (is_wr) begin
      mdr_m = data;
    end
    check("txn_ended", 64'(ended), 64'(1));
    check("first_req_cycle", 64'(first_req), 64'(0));
    check("req_cycles", 64'(req_n), ok ? 64'(delay + 1) : 64'(Timeout));
    check("busy_cycles", 64'(busy_n), ok ? 64'(delay + 2) : 64'(Timeout));
    check("done_count", 64'(done_n), 64'(ok));
    check("done_at", 64'(done_at), ok ? 64'(delay + 1) : 64'(-1));
    check("err_count", 64'(err_n), (!ok || poke > 0) ? 64'(1) : 64'(0));
    check("done_err_overlap", 64'(both_n), 64'(0));
    check("addr_stable", 64'(addr_bad), 64'(0));
    check("we_stable", 64'(we_bad), 64'(0));
    check("wdata_stable", 64'(wd_bad), 64'(0));
    check("mdr_after", 64'(MDataOut), 64'(mdr_m));
    check("req_low_after", 64'(mem_req), 64'(0));
  endtask

  initial begin
    // Reset held
    repeat (3) tick();
    check("rst_req", 64'(mem_req), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_mdr", 64'(MDataOut), 64'(0));
    check("rst_flags", 64'({MemBusy, MemDone, MemErr}), 64'(0));
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_quiet", 64'({mem_req, MemBusy, MemDone, MemErr}), 64'(0));
    end

    // Write then read back the same word with same-cycle ack
    do_txn(1'b1, 9'h005, 32'hDEADBEEF, 2, -1);
    do_txn(1'b0, 9'h005, 32'h0, 0, -1);
    check("read_back", 64'(MDataOut), 64'h0000_0000_DEAD_BEEF);

    // Read with no ack: timeout, MDR untouched
    do_txn(1'b0, 9'h033, 32'h0, int'(Timeout) + 4, -1);

    // Read+Write collision
    Read = 1'b1; Write = 1'b1;
    tick();
    check("coll_req", 64'(mem_req), 64'(0));
    check("coll_err", 64'(MemErr), 64'(1));
    check("coll_busy", 64'(MemBusy), 64'(0));
    Read = 1'b0; Write = 1'b0;
    tick();
    check("coll_err_once", 64'(MemErr), 64'(0));

    // Second Read edge while in REQ
    do_txn(1'b0, 9'h005, 32'h0, 3, 2);

    // Bus load of MDR while idle
    BusMuxOut = 32'h1234_5678; MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    mdr_m = 32'h1234_5678;
    check("mdrin_load", 64'(MDataOut), 64'(mdr_m));

    // Reset in the middle of a request
    BusMuxOut = 32'h0AA; MARin = 1'b1;
    tick();
    MARin = 1'b0; Read = 1'b1;
    tick();
    Read = 1'b0;
    tick();
    check("pre_reset_req", 64'(mem_req), 64'(1));
    #2 Reset = 1'b1;
    #1;
    check("async_rst_req", 64'(mem_req), 64'(0));
    check("async_rst_mdr", 64'(MDataOut), 64'(0));
    check("async_rst_busy", 64'(MemBusy), 64'(0));
    mdr_m = '0;
    tick();
    check("rst_no_done", 64'({MemDone, MemErr}), 64'(0));
    Reset = 1'b0;
    tick();
    do_txn(1'b0, 9'h0AA, 32'h0, 1, -1);

    // Randomised transactions
    for (int t = 0; t < 40; t++) begin
      bit            wr;
      logic [Aw-1:0] a;
      int            dly, pk;
      wr  = 1'($urandom_range(0, 1));
      a   = Aw'($urandom_range(0, 15));
      dly = ($urandom_range(0, 7) == 0) ? int'(Timeout) + 1 : int'($urandom_range(0, 5));
      pk  = (dly < int'(Timeout) && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, dly + 1))
                                                              : -1;
      do_txn(wr, a, $urandom, dly, pk);
      if ($urandom_range(0, 3) == 0) begin
        BusMuxOut = $urandom; MDRin = 1'b1;
        mdr_m = BusMuxOut;
        tick();
        MDRin = 1'b0;
        check("rand_mdrin", 64'(MDataOut), 64'(mdr_m));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
